// File: rtl/shift_reg.sv
// shift_reg: serial-in/serial-out shift register with a counted shift command.
//
// Serializes bits from the memory-side serial input onto po. A non-zero
// shift command accepted while idle requests that many single-bit shifts;
// each shift happens only on an edge where validin is high.
//
// Ports:
//   clk      - system clock, rising-edge active
//   rst      - asynchronous, active-high reset (clears data and count)
//   si       - serial data in, loaded into bit 0 on each shift
//   shift    - shift request (number of shifts), 0 = no request
//   validin  - qualifier for shifting and request acceptance
//   po       - serial data out, register MSB
module shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            si,
    input  logic [CNTW-1:0] shift,
    input  logic            validin,
    output logic            po
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  cnt_next;
    state_t           state;

    // Busy/idle is fully determined by the remaining-shift count, so the
    // state is decoded from cnt rather than held in its own flop.
    always_comb begin
        state = (cnt == '0) ? IDLE : BUSY;
    end

    always_comb begin
        sreg_next = sreg;
        cnt_next  = cnt;
        unique case (state)
            IDLE: begin
                // The accepting edge performs the first of the N shifts,
                // hence N-1 remaining.
                if (validin && (shift != '0)) begin
                    sreg_next = {sreg[WIDTH-2:0], si};
                    cnt_next  = shift - CNTW'(1);
                end
            end
            BUSY: begin
                // Requests arriving while busy are dropped, not queued.
                if (validin) begin
                    sreg_next = {sreg[WIDTH-2:0], si};
                    cnt_next  = cnt - CNTW'(1);
                end
            end
            default: begin
                sreg_next = sreg;
                cnt_next  = cnt;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else begin
            sreg <= sreg_next;
            cnt  <= cnt_next;
        end
    end

    assign po = sreg[WIDTH-1];

endmodule

// File: tb/tb_shift_reg.sv
// tb_shift_reg: directed self-checking bench for shift_reg.
module tb_shift_reg;

    logic       clk;
    logic       rst;
    logic       si;
    logic [7:0] shift;
    logic       validin;
    logic       po;

    int unsigned total;
    int unsigned bad;

    logic [7:0] ones_tbl [8];
    logic [7:0] seq_bits;

    shift_reg #(.WIDTH(8), .CNTW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .si      (si),
        .shift   (shift),
        .validin (validin),
        .po      (po)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, then
    // return 1 time unit after it so outputs are sampled off the edge.
    task automatic cycle(input logic v, input logic [7:0] sh, input logic s);
        @(negedge clk);
        validin = v;
        shift   = sh;
        si      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        validin = 1'b0;
        shift   = '0;
        si      = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        si      = 1'b0;
        shift   = '0;
        validin = 1'b0;
        ones_tbl = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        seq_bits = 8'b0100_1101; // bit i is driven on the i-th edge: 1,0,1,1,0,0,1,0

        // ---------------- reset state ----------------
        #3;
        check("rst_po", po, 1'b0);
        check("rst_sreg", dut.sreg, 8'h00);
        check("rst_cnt", dut.cnt, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // fill with ones, then async reset mid-cycle
        cycle(1'b1, 8'd8, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'd0, 1'b1);
        check("fill_sreg", dut.sreg, 8'hFF);
        check("fill_po", po, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_po", po, 1'b0);
        check("async_rst_sreg", dut.sreg, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'd0, 1'b1);
            check("post_rst_idle_po", po, 1'b0);
        end
        check("post_rst_idle_sreg", dut.sreg, 8'h00);

        // ---------------- single-shift pulses ----------------
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 8'd1, 1'b1);
            check("pulse_shift_sreg", dut.sreg, ones_tbl[k]);
            check("pulse_cnt", dut.cnt, 8'd0);
            cycle(1'b1, 8'd0, 1'b1);
            check("pulse_hold_sreg", dut.sreg, ones_tbl[k]);
        end
        check("pulse_po", po, 1'b1);

        // ---------------- counted request of 8 ----------------
        do_reset();
        cycle(1'b1, 8'd8, seq_bits[0]);
        check("cnt8_accept_cnt", dut.cnt, 8'd7);
        check("cnt8_accept_sreg", dut.sreg, 8'h01);
        for (int i = 1; i < 8; i++) cycle(1'b1, 8'd0, seq_bits[i]);
        check("cnt8_sreg", dut.sreg, 8'b1011_0010);
        check("cnt8_po", po, 1'b1);
        check("cnt8_idle", dut.cnt, 8'd0);
        cycle(1'b1, 8'd0, 1'b1);
        check("cnt8_after_hold", dut.sreg, 8'b1011_0010);

        // ---------------- busy drop ----------------
        do_reset();
        cycle(1'b1, 8'd4, 1'b1);
        check("drop_accept", dut.sreg, 8'h01);
        cycle(1'b1, 8'd0, 1'b1);
        check("drop_busy1", dut.sreg, 8'h03);
        cycle(1'b1, 8'd3, 1'b1);
        check("drop_busy2", dut.sreg, 8'h07);
        check("drop_busy2_cnt", dut.cnt, 8'd1);
        cycle(1'b1, 8'd0, 1'b1);
        check("drop_done", dut.sreg, 8'h0F);
        check("drop_done_cnt", dut.cnt, 8'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'd0, 1'b1);
            check("drop_no_extra", dut.sreg, 8'h0F);
        end

        // ---------------- validin pause ----------------
        do_reset();
        cycle(1'b1, 8'd5, 1'b1);
        cycle(1'b1, 8'd0, 1'b0);
        check("pause_pre", dut.sreg, 8'h02);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'd0, 1'b1);
            check("pause_sreg", dut.sreg, 8'h02);
            check("pause_cnt", dut.cnt, 8'd3);
        end
        cycle(1'b1, 8'd0, 1'b1);
        check("resume1", dut.sreg, 8'h05);
        cycle(1'b1, 8'd0, 1'b1);
        check("resume2", dut.sreg, 8'h0B);
        cycle(1'b1, 8'd0, 1'b0);
        check("resume3", dut.sreg, 8'h16);
        check("pause_done_cnt", dut.cnt, 8'd0);
        cycle(1'b1, 8'd0, 1'b1);
        check("pause_after_hold", dut.sreg, 8'h16);

        // ---------------- maximum request, no wrap ----------------
        do_reset();
        cycle(1'b1, 8'hFF, 1'b0);
        check("max_accept_cnt", dut.cnt, 8'd254);
        for (int i = 0; i < 254; i++) cycle(1'b1, 8'd0, 1'b1);
        check("max_done_cnt", dut.cnt, 8'd0);
        check("max_sreg", dut.sreg, 8'hFF);
        cycle(1'b1, 8'd0, 1'b0);
        check("max_no_wrap_sreg", dut.sreg, 8'hFF);
        check("max_no_wrap_cnt", dut.cnt, 8'd0);

        // ---------------- reset mid-operation ----------------
        do_reset();
        cycle(1'b1, 8'd200, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'd0, 1'b1);
        check("midop_cnt", dut.cnt, 8'd190);
        check("midop_po", po, 1'b1);
        #2;
        shift = '0;
        rst   = 1'b1;
        #1;
        check("midop_rst_po", po, 1'b0);
        check("midop_rst_cnt", dut.cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'd0, 1'b1);
            check("midop_after_po", po, 1'b0);
        end
        check("midop_after_sreg", dut.sreg, 8'h00);
        check("midop_after_cnt", dut.cnt, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
